// File: rtl/axi_tg_pkg.sv
// Shared types and helpers for the AXI write/read-back traffic generator.
// Used by axi_master_traffic_gen and its saturating counter sub-module.
package axi_tg_pkg;

  localparam int unsigned TG_MAX_W = 512;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_NEXT = 3'd6
  } state_e;

  function automatic int unsigned tg_bytes(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned tg_size(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int unsigned tg_burst_bytes(input int unsigned beats, input int unsigned data_w);
    return beats * (data_w / 8);
  endfunction

  // Operands are zero-extended to TG_MAX_W by the caller and truncated back afterwards.
  function automatic logic [TG_MAX_W-1:0] pattern(input logic [TG_MAX_W-1:0] seed,
                                                  input logic [TG_MAX_W-1:0] addr);
    return seed ^ addr;
  endfunction

endpackage

// File: rtl/axi_master_traffic_gen_if.sv
// AXI4 bus interface with Master/Slave modports, carried between the
// traffic generator and the SoC crossbar (or a bench memory model).
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 10
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/axi_tg_sat_cnt.sv
// Saturating up-counter with synchronous clear; used for the error and
// read-back mismatch tallies.
module axi_tg_sat_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/axi_master_traffic_gen.sv
// AXI4 write sweep traffic generator with optional read-back check.
// Read-back is compiled in when AXI_TG_READBACK_EN is defined.
module axi_master_traffic_gen
  import axi_tg_pkg::*;
#(
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 10,
  parameter int unsigned BEATS          = 4,
  parameter logic [63:0] START_ADDR     = 64'h9000_0000,
  parameter logic [63:0] END_ADDR       = 64'h9000_0100,
  parameter logic [63:0] PATTERN_SEED   = 64'hdead_beef_1234_5678
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          loop_i,
  input  logic          stop_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [31:0]   txn_cnt_o,
  output logic [15:0]   err_cnt_o,
  output logic [15:0]   mismatch_cnt_o,
  output state_e        dbg_state_o,
  AXI_BUS.Master        axi_master_port
);

  localparam int unsigned BYTES       = tg_bytes(AXI_DATA_WIDTH);
  localparam int unsigned SIZE        = tg_size(AXI_DATA_WIDTH);
  localparam int unsigned BURST_BYTES = tg_burst_bytes(BEATS, AXI_DATA_WIDTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] START_A = AXI_ADDR_WIDTH'(START_ADDR);
  localparam logic [AXI_ADDR_WIDTH-1:0] END_A   = AXI_ADDR_WIDTH'(END_ADDR);
  localparam logic [AXI_ADDR_WIDTH-1:0] BURST_A = AXI_ADDR_WIDTH'(BURST_BYTES);
  localparam logic [7:0]                LEN     = 8'(BEATS - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Valid is raised without waiting for ready and, with its payload, held
  // stable until that edge; ready may toggle freely.

  state_e                    r_state;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]                r_beat;
  logic                      r_loop;
  logic                      r_stop;
  logic                      r_done;
  logic                      r_aw_valid;
  logic                      r_w_valid;
  logic                      r_b_ready;
  logic [31:0]               r_txn;

  logic [AXI_ADDR_WIDTH-1:0] w_beat_addr;
  logic [AXI_ADDR_WIDTH-1:0] w_next_addr;
  logic [TG_MAX_W-1:0]       w_pat_full;
  logic [AXI_DATA_WIDTH-1:0] w_pat_data;
  logic                      w_last_beat;
  logic                      w_fits;
  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic                      w_b_hs;
  logic                      w_stop_req;
  logic                      w_clr;
  logic                      w_err_en;

  assign w_beat_addr = r_addr + (AXI_ADDR_WIDTH'(r_beat) << SIZE);
  assign w_next_addr = r_addr + BURST_A;
  assign w_fits      = (w_next_addr + BURST_A) <= END_A;
  assign w_pat_full  = pattern(TG_MAX_W'(PATTERN_SEED), TG_MAX_W'(w_beat_addr));
  assign w_pat_data  = w_pat_full[AXI_DATA_WIDTH-1:0];
  assign w_last_beat = (r_beat == LEN);
  assign w_aw_hs     = r_aw_valid & axi_master_port.aw_ready;
  assign w_w_hs      = r_w_valid & axi_master_port.w_ready;
  assign w_b_hs      = r_b_ready & axi_master_port.b_valid;
  assign w_stop_req  = r_stop | stop_i;
  assign w_clr       = (r_state == S_IDLE) && start_i;

`ifdef AXI_TG_READBACK_EN
  logic r_ar_valid;
  logic r_r_ready;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_mis_en;

  assign w_ar_hs  = r_ar_valid & axi_master_port.ar_ready;
  assign w_r_hs   = r_r_ready & axi_master_port.r_valid;
  assign w_mis_en = w_r_hs && (axi_master_port.r_data != w_pat_data);
  assign w_err_en = (w_b_hs && (axi_master_port.b_resp != 2'b00)) ||
                    (w_r_hs && (axi_master_port.r_resp != 2'b00));
`else
  assign w_err_en = w_b_hs && (axi_master_port.b_resp != 2'b00);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_addr     <= START_A;
      r_beat     <= '0;
      r_loop     <= 1'b0;
      r_stop     <= 1'b0;
      r_done     <= 1'b0;
      r_aw_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      r_b_ready  <= 1'b0;
      r_txn      <= '0;
`ifdef AXI_TG_READBACK_EN
      r_ar_valid <= 1'b0;
      r_r_ready  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      // Stop is only honoured between bursts, so remember it until NEXT.
      if (stop_i && (r_state != S_IDLE)) r_stop <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_loop     <= loop_i;
            r_stop     <= 1'b0;
            r_addr     <= START_A;
            r_txn      <= '0;
            r_aw_valid <= 1'b1;
            r_state    <= S_AW;
          end
        end
        S_AW: begin
          if (w_aw_hs) begin
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b1;
            r_beat     <= '0;
            r_state    <= S_W;
          end
        end
        S_W: begin
          if (w_w_hs) begin
            if (w_last_beat) begin
              r_w_valid <= 1'b0;
              r_b_ready <= 1'b1;
              r_state   <= S_B;
            end else begin
              r_beat <= r_beat + 8'd1;
            end
          end
        end
        S_B: begin
          if (w_b_hs) begin
            r_b_ready <= 1'b0;
            r_txn     <= r_txn + 32'd1;
`ifdef AXI_TG_READBACK_EN
            r_ar_valid <= 1'b1;
            r_state    <= S_AR;
`else
            r_state    <= S_NEXT;
`endif
          end
        end
`ifdef AXI_TG_READBACK_EN
        S_AR: begin
          if (w_ar_hs) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
            r_beat     <= '0;
            r_state    <= S_R;
          end
        end
        S_R: begin
          if (w_r_hs) begin
            r_beat <= r_beat + 8'd1;
            if (axi_master_port.r_last) begin
              r_r_ready <= 1'b0;
              r_state   <= S_NEXT;
            end
          end
        end
`endif
        S_NEXT: begin
          if (w_stop_req) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_fits) begin
            r_addr     <= w_next_addr;
            r_aw_valid <= 1'b1;
            r_state    <= S_AW;
          end else if (r_loop) begin
            r_addr     <= START_A;
            r_aw_valid <= 1'b1;
            r_state    <= S_AW;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  axi_tg_sat_cnt #(.WIDTH(16)) u_err_cnt (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_clr   (w_clr),
    .i_en    (w_err_en),
    .o_cnt   (err_cnt_o)
  );

`ifdef AXI_TG_READBACK_EN
  axi_tg_sat_cnt #(.WIDTH(16)) u_mis_cnt (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_clr   (w_clr),
    .i_en    (w_mis_en),
    .o_cnt   (mismatch_cnt_o)
  );
  assign axi_master_port.ar_addr  = r_addr;
  assign axi_master_port.ar_valid = r_ar_valid;
  assign axi_master_port.r_ready  = r_r_ready;
`else
  assign mismatch_cnt_o           = '0;
  assign axi_master_port.ar_addr  = '0;
  assign axi_master_port.ar_valid = 1'b0;
  assign axi_master_port.r_ready  = 1'b1;
`endif

  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;
  assign txn_cnt_o   = r_txn;
  assign dbg_state_o = r_state;

  assign axi_master_port.aw_id     = '0;
  assign axi_master_port.aw_addr   = r_addr;
  assign axi_master_port.aw_len    = LEN;
  assign axi_master_port.aw_size   = 3'(SIZE);
  assign axi_master_port.aw_burst  = 2'b01;
  assign axi_master_port.aw_lock   = 1'b0;
  assign axi_master_port.aw_cache  = 4'b0000;
  assign axi_master_port.aw_prot   = 3'b000;
  assign axi_master_port.aw_qos    = 4'b0000;
  assign axi_master_port.aw_region = 4'b0000;
  assign axi_master_port.aw_atop   = 6'b000000;
  assign axi_master_port.aw_user   = '0;
  assign axi_master_port.aw_valid  = r_aw_valid;

  assign axi_master_port.w_data    = w_pat_data;
  assign axi_master_port.w_strb    = '1;
  assign axi_master_port.w_last    = w_last_beat;
  assign axi_master_port.w_user    = '0;
  assign axi_master_port.w_valid   = r_w_valid;

  assign axi_master_port.b_ready   = r_b_ready;

  assign axi_master_port.ar_id     = '0;
  assign axi_master_port.ar_len    = LEN;
  assign axi_master_port.ar_size   = 3'(SIZE);
  assign axi_master_port.ar_burst  = 2'b01;
  assign axi_master_port.ar_lock   = 1'b0;
  assign axi_master_port.ar_cache  = 4'b0000;
  assign axi_master_port.ar_prot   = 3'b000;
  assign axi_master_port.ar_qos    = 4'b0000;
  assign axi_master_port.ar_region = 4'b0000;
  assign axi_master_port.ar_user   = '0;

endmodule

// File: tb/tb_axi_master_traffic_gen.sv
// Directed bench for axi_master_traffic_gen: a memory slave with stall/error
// knobs, handshake logs, and per-scenario tasks with hand-computed values.
module tb_axi_master_traffic_gen;
  import axi_tg_pkg::*;

  localparam logic [63:0] SEED  = 64'hdead_beef_1234_5678;
  localparam logic [63:0] START = 64'h9000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, loop_en, stop;
  logic        busy, done;
  logic [31:0] txn_cnt;
  logic [15:0] err_cnt, mis_cnt;
  state_e      dbg_state;

  AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(10)) axi_bus ();

  axi_master_traffic_gen dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .loop_i          (loop_en),
    .stop_i          (stop),
    .busy_o          (busy),
    .done_o          (done),
    .txn_cnt_o       (txn_cnt),
    .err_cnt_o       (err_cnt),
    .mismatch_cnt_o  (mis_cnt),
    .dbg_state_o     (dbg_state),
    .axi_master_port (axi_bus)
  );

  int checks = 0;
  int failures = 0;

  // slave knobs and logs
  int          aw_stall = 0;
  bit          w_toggle = 0;
  int          err_at = 0;
  bit          corrupt_en = 0;
  logic [63:0] corrupt_addr = '0;
  logic [63:0] aw_log[$];
  logic [63:0] ar_log[$];
  logic [63:0] wd_log[$];
  bit          wl_log[$];
  logic [63:0] exp_q[$];
  int          field_bad, stable_bad, b_seen, b_cnt, done_pulses;
  logic [63:0] mem [logic [63:0]];

  // slave private state
  bit          b_pend, b_hs, r_act, r_hs, aw_wait;
  int          wbeat, r_beat;
  logic [63:0] r_base, aw_hold, rd_a, rd_d;

  initial begin
    axi_bus.aw_ready = 1'b0; axi_bus.w_ready = 1'b1; axi_bus.b_valid = 1'b0;
    axi_bus.b_resp = 2'b00;  axi_bus.b_id = '0;      axi_bus.b_user = '0;
    axi_bus.ar_ready = 1'b0; axi_bus.r_valid = 1'b0; axi_bus.r_data = '0;
    axi_bus.r_resp = 2'b00;  axi_bus.r_last = 1'b0;  axi_bus.r_id = '0;
    axi_bus.r_user = '0;
  end

  // Slave: drive on negedge, sample handshakes at negedge+1 (they complete at the next posedge).
  always begin
    @(negedge clk);
    if (!rst_n) begin
      axi_bus.aw_ready = 1'b0; axi_bus.w_ready = 1'b1; axi_bus.b_valid = 1'b0;
      axi_bus.ar_ready = 1'b0; axi_bus.r_valid = 1'b0; axi_bus.r_last = 1'b0;
      b_pend = 0; b_hs = 0; r_act = 0; r_hs = 0; aw_wait = 0; wbeat = 0; r_beat = 0;
    end else begin
      if (aw_stall > 0) begin
        axi_bus.aw_ready = 1'b0;
        if (axi_bus.aw_valid) aw_stall--;
      end else begin
        axi_bus.aw_ready = 1'b1;
      end
      axi_bus.w_ready  = w_toggle ? !axi_bus.w_ready : 1'b1;
      axi_bus.ar_ready = 1'b1;
      if (b_hs) begin axi_bus.b_valid = 1'b0; b_hs = 0; end
      if (b_pend && !axi_bus.b_valid) begin
        b_cnt++;
        axi_bus.b_resp  = (b_cnt == err_at) ? 2'b10 : 2'b00;
        axi_bus.b_valid = 1'b1;
        b_pend = 0;
      end
      if (r_hs) begin
        axi_bus.r_valid = 1'b0; r_hs = 0; r_beat++;
        if (r_beat == 4) r_act = 0;
      end
      if (r_act && !axi_bus.r_valid) begin
        rd_a = r_base + 64'(r_beat * 8);
        rd_d = mem.exists(rd_a) ? mem[rd_a] : 64'h0;
        if (corrupt_en && (rd_a == corrupt_addr)) rd_d = ~rd_d;
        axi_bus.r_data = rd_d; axi_bus.r_resp = 2'b00;
        axi_bus.r_last = (r_beat == 3); axi_bus.r_valid = 1'b1;
      end
    end
    #1;
    if (rst_n) begin
      if (axi_bus.aw_valid) begin
        if (aw_wait && (axi_bus.aw_addr !== aw_hold)) stable_bad++;
        if (axi_bus.aw_ready) begin
          aw_log.push_back(axi_bus.aw_addr);
          if (axi_bus.aw_len !== 8'd3 || axi_bus.aw_size !== 3'd3 || axi_bus.aw_burst !== 2'b01) field_bad++;
          aw_wait = 0;
        end else begin
          aw_wait = 1; aw_hold = axi_bus.aw_addr;
        end
      end else if (aw_wait) begin
        stable_bad++; aw_wait = 0;
      end
      if (axi_bus.w_valid && axi_bus.w_ready) begin
        wd_log.push_back(axi_bus.w_data);
        wl_log.push_back(axi_bus.w_last);
        if (aw_log.size() > 0) mem[aw_log[$] + 64'(wbeat * 8)] = axi_bus.w_data;
        wbeat++;
        if (wbeat == 4) begin wbeat = 0; b_pend = 1; end
      end
      if (axi_bus.b_valid && axi_bus.b_ready) begin b_hs = 1; b_seen++; end
      if (axi_bus.ar_valid && axi_bus.ar_ready) begin
        ar_log.push_back(axi_bus.ar_addr);
        r_act = 1; r_base = axi_bus.ar_addr; r_beat = 0;
      end
      if (axi_bus.r_valid && axi_bus.r_ready) r_hs = 1;
      if (done) done_pulses++;
    end
  end

  task automatic clear_logs();
    aw_log.delete(); ar_log.delete(); wd_log.delete(); wl_log.delete(); exp_q.delete();
    field_bad = 0; stable_bad = 0; b_seen = 0; b_cnt = 0; done_pulses = 0;
  endtask

  task automatic pulse_start(input bit lp);
    @(negedge clk); loop_en = lp; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (!busy) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    logic exp_rr;
`ifdef AXI_TG_READBACK_EN
    exp_rr = 1'b0;
`else
    exp_rr = 1'b1;
`endif
    checks++; if ({axi_bus.aw_valid, axi_bus.w_valid, axi_bus.b_ready, axi_bus.ar_valid} !== 4'b0000) begin
      failures++; $display("FAIL reset_valids got=%b exp=0000", {axi_bus.aw_valid, axi_bus.w_valid, axi_bus.b_ready, axi_bus.ar_valid}); end
    checks++; if (axi_bus.r_ready !== exp_rr) begin failures++; $display("FAIL reset_r_ready got=%b exp=%b", axi_bus.r_ready, exp_rr); end
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
    checks++; if ({txn_cnt, err_cnt, mis_cnt} !== 64'h0) begin
      failures++; $display("FAIL reset_counters got=%h/%h/%h exp=0", txn_cnt, err_cnt, mis_cnt); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
  endtask

  task automatic check_w_stream(input string tag);
    int dbad = 0, lbad = 0;
    logic [63:0] exp_d;
    for (int i = 0; i < wd_log.size(); i++) begin
      exp_d = SEED ^ (START + 64'(i * 8));
      if (wd_log[i] !== exp_d) dbad++;
      if (wl_log[i] !== ((i % 4) == 3)) lbad++;
    end
    checks++; if (wd_log.size() != 32) begin failures++; $display("FAIL %s_w_beats got=%0d exp=32", tag, wd_log.size()); end
    checks++; if (dbad != 0) begin failures++; $display("FAIL %s_w_data bad_beats=%0d exp=0", tag, dbad); end
    checks++; if (lbad != 0) begin failures++; $display("FAIL %s_w_last bad_beats=%0d exp=0", tag, lbad); end
  endtask

  task automatic test_sweep();
    bit ok;
    logic [63:0] got;
    clear_logs();
    for (int k = 0; k < 8; k++) exp_q.push_back(START + 64'(k * 32));
    pulse_start(1'b0);
    wait_idle(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL sweep_timeout got=busy exp=idle"); end
    checks++; if (aw_log.size() != 8) begin failures++; $display("FAIL sweep_aw_count got=%0d exp=8", aw_log.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (k < aw_log.size()) ? aw_log[k] : 64'hffff_ffff_ffff_ffff;
      checks++; if (got !== exp_q[k]) begin failures++; $display("FAIL sweep_aw_addr[%0d] got=%h exp=%h", k, got, exp_q[k]); end
    end
    checks++; if (field_bad != 0) begin failures++; $display("FAIL sweep_aw_fields bad=%0d exp=0", field_bad); end
    checks++; if (wd_log.size() == 0 || wd_log[0] !== 64'hdead_beef_8234_5678) begin
      failures++; $display("FAIL sweep_first_beat got=%h exp=deadbeef82345678", (wd_log.size() > 0) ? wd_log[0] : 64'h0); end
    check_w_stream("sweep");
    checks++; if (done_pulses != 1) begin failures++; $display("FAIL sweep_done_pulses got=%0d exp=1", done_pulses); end
    checks++; if (txn_cnt !== 32'd8) begin failures++; $display("FAIL sweep_txn got=%0d exp=8", txn_cnt); end
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL sweep_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_stall();
    bit ok;
    clear_logs();
    aw_stall = 5; w_toggle = 1;
    pulse_start(1'b0);
    wait_idle(2000, ok);
    w_toggle = 0;
    checks++; if (!ok) begin failures++; $display("FAIL stall_timeout got=busy exp=idle"); end
    checks++; if (aw_stall != 0) begin failures++; $display("FAIL stall_not_applied left=%0d exp=0", aw_stall); end
    checks++; if (stable_bad != 0) begin failures++; $display("FAIL stall_aw_stable bad=%0d exp=0", stable_bad); end
    checks++; if (aw_log.size() != 8) begin failures++; $display("FAIL stall_aw_count got=%0d exp=8", aw_log.size()); end
    check_w_stream("stall");
    checks++; if (txn_cnt !== 32'd8) begin failures++; $display("FAIL stall_txn got=%0d exp=8", txn_cnt); end
  endtask

  task automatic test_slverr();
    bit ok;
    clear_logs();
    err_at = 3;
    pulse_start(1'b0);
    wait_idle(2000, ok);
    err_at = 0;
    checks++; if (!ok) begin failures++; $display("FAIL slverr_timeout got=busy exp=idle"); end
    checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL slverr_err got=%0d exp=1", err_cnt); end
    checks++; if (txn_cnt !== 32'd8) begin failures++; $display("FAIL slverr_txn got=%0d exp=8", txn_cnt); end
    checks++; if (done_pulses != 1) begin failures++; $display("FAIL slverr_done got=%0d exp=1", done_pulses); end
  endtask

  task automatic test_loop_stop();
    bit ok, hit;
    clear_logs();
    pulse_start(1'b1);
    hit = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #2;
      if (aw_log.size() >= 9) begin hit = 1; break; end
    end
    checks++; if (!hit || aw_log[8] !== START) begin
      failures++; $display("FAIL loop_wrap_addr got=%h exp=%h", hit ? aw_log[8] : 64'h0, START); end
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      if (wd_log.size() == 34) begin hit = 1; break; end
      @(negedge clk); #2;
    end
    checks++; if (!hit) begin failures++; $display("FAIL loop_mid_w got=%0d exp=34", wd_log.size()); end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_idle(500, ok);
    loop_en = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL stop_timeout got=busy exp=idle"); end
    checks++; if (wd_log.size() != 36) begin failures++; $display("FAIL stop_burst_beats got=%0d exp=36", wd_log.size()); end
    checks++; if (b_seen != 9) begin failures++; $display("FAIL stop_b_seen got=%0d exp=9", b_seen); end
    checks++; if (txn_cnt !== 32'd9) begin failures++; $display("FAIL stop_txn got=%0d exp=9", txn_cnt); end
    checks++; if (done_pulses != 1) begin failures++; $display("FAIL stop_done got=%0d exp=1", done_pulses); end
    repeat (20) @(negedge clk);
    checks++; if (aw_log.size() != 9) begin failures++; $display("FAIL stop_extra_aw got=%0d exp=9", aw_log.size()); end
  endtask

  task automatic test_readback();
    bit ok;
    int abad = 0;
    clear_logs();
    corrupt_en = 1; corrupt_addr = 64'h9000_0048;
    pulse_start(1'b0);
    wait_idle(3000, ok);
    corrupt_en = 0;
    checks++; if (!ok) begin failures++; $display("FAIL rb_timeout got=busy exp=idle"); end
`ifdef AXI_TG_READBACK_EN
    for (int k = 0; k < ar_log.size(); k++) if (k >= aw_log.size() || ar_log[k] !== aw_log[k]) abad++;
    checks++; if (ar_log.size() != 8) begin failures++; $display("FAIL rb_ar_count got=%0d exp=8", ar_log.size()); end
    checks++; if (abad != 0) begin failures++; $display("FAIL rb_ar_addr bad=%0d exp=0", abad); end
    checks++; if (mis_cnt !== 16'd1) begin failures++; $display("FAIL rb_mismatch got=%0d exp=1", mis_cnt); end
`else
    checks++; if (ar_log.size() != 0) begin failures++; $display("FAIL rb_ar_count got=%0d exp=0", ar_log.size()); end
    checks++; if (axi_bus.r_ready !== 1'b1) begin failures++; $display("FAIL rb_r_ready got=%b exp=1", axi_bus.r_ready); end
    checks++; if (mis_cnt !== 16'd0) begin failures++; $display("FAIL rb_mismatch got=%0d exp=0", mis_cnt); end
`endif
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL rb_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok, hit;
    clear_logs();
    pulse_start(1'b0);
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      if (wd_log.size() == 11) begin hit = 1; break; end
      @(negedge clk); #2;
    end
    checks++; if (!hit) begin failures++; $display("FAIL rstmid_reach got=%0d exp=11", wd_log.size()); end
    checks++; if (txn_cnt !== 32'd2) begin failures++; $display("FAIL rstmid_txn_before got=%0d exp=2", txn_cnt); end
    rst_n = 1'b0;
    @(negedge clk); #2;
    checks++; if ({axi_bus.aw_valid, axi_bus.w_valid, axi_bus.b_ready, axi_bus.ar_valid} !== 4'b0000) begin
      failures++; $display("FAIL rstmid_valids got=%b exp=0000", {axi_bus.aw_valid, axi_bus.w_valid, axi_bus.b_ready, axi_bus.ar_valid}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if ({txn_cnt, err_cnt, mis_cnt} !== 64'h0) begin
      failures++; $display("FAIL rstmid_counters got=%h/%h/%h exp=0", txn_cnt, err_cnt, mis_cnt); end
    rst_n = 1'b1;
    clear_logs();
    pulse_start(1'b0);
    hit = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #2;
      if (aw_log.size() >= 1) begin hit = 1; break; end
    end
    checks++; if (!hit || aw_log[0] !== START) begin
      failures++; $display("FAIL rstmid_restart_addr got=%h exp=%h", hit ? aw_log[0] : 64'h0, START); end
    wait_idle(2000, ok);
    checks++; if (!ok || txn_cnt !== 32'd8) begin failures++; $display("FAIL rstmid_rerun_txn got=%0d exp=8", txn_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; loop_en = 1'b0; stop = 1'b0;
    clear_logs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #2;
    test_reset();
    test_sweep();
    test_stall();
    test_slverr();
    test_loop_stop();
    test_readback();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
